// File: rtl/am2901_pkg.sv
// Shared microinstruction field encodings for the Am2901 ALU slice.
package am2901_pkg;

    typedef enum logic [2:0] {
        SrcAq, SrcAb, SrcZq, SrcZb, SrcZa, SrcDa, SrcDq, SrcDz
    } src_e;

    typedef enum logic [2:0] {
        FnAdd, FnSubr, FnSubs, FnOr, FnAnd, FnNotrs, FnExor, FnExnor
    } fn_e;

    typedef enum logic [2:0] {
        DstQreg, DstNop, DstRama, DstRamf, DstRamqd, DstRamd, DstRamqu, DstRamu
    } dst_e;

    localparam int unsigned RamDepth = 16;

endpackage

// File: rtl/am2901_ram.sv
// 16-word register file: asynchronous clear, two combinational read ports, one write port.
module am2901_ram #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [3:0]   addr_a,
    input  logic [3:0]   addr_b,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata_a,
    output logic [W-1:0] rdata_b
);
    import am2901_pkg::*;

    logic [W-1:0] mem_q [RamDepth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RamDepth; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we) begin
            mem_q[addr_b] <= wdata;
        end
    end

    assign rdata_a = mem_q[addr_a];
    assign rdata_b = mem_q[addr_b];

endmodule

// File: rtl/am2901.sv
// Am2901 four-bit ALU slice: register file, Q register, 8-function ALU, RAM/Q shifters,
// and carry look-ahead generate/propagate for cascading.
module am2901 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [8:0]   i,
    input  logic [3:0]   a,
    input  logic [3:0]   b,
    input  logic [W-1:0] d,
    input  logic         cin,
    input  logic         ram0_in,
    input  logic         ram3_in,
    input  logic         q0_in,
    input  logic         q3_in,
    output logic         ram0_out,
    output logic         ram0_oe,
    output logic         ram3_out,
    output logic         ram3_oe,
    output logic         q0_out,
    output logic         q0_oe,
    output logic         q3_out,
    output logic         q3_oe,
    output logic [W-1:0] y,
    output logic         f3,
    output logic         f_zero,
    output logic         cn4,
    output logic         ovr,
    output logic         g_n,
    output logic         p_n
);
    import am2901_pkg::*;

    src_e src;
    fn_e  fn;
    dst_e dst;

    logic [W-1:0] q_q, q_d;
    logic         q_we;
    logic [W-1:0] ram_a, ram_b, ram_wdata;
    logic         ram_we;
    logic [W-1:0] r, s, rp, sp, f;
    logic [W:0]   sum;
    logic         arith, c_msb, gen;

    assign src = src_e'(i[2:0]);
    assign fn  = fn_e'(i[5:3]);
    assign dst = dst_e'(i[8:6]);

    am2901_ram #(.W(W)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we & ce),
        .addr_a  (a),
        .addr_b  (b),
        .wdata   (ram_wdata),
        .rdata_a (ram_a),
        .rdata_b (ram_b)
    );

    always_comb begin
        r = '0;
        s = '0;
        case (src)
            SrcAq: begin r = ram_a; s = q_q;   end
            SrcAb: begin r = ram_a; s = ram_b; end
            SrcZq: s = q_q;
            SrcZb: s = ram_b;
            SrcZa: s = ram_a;
            SrcDa: begin r = d; s = ram_a; end
            SrcDq: begin r = d; s = q_q;   end
            SrcDz: r = d;
        endcase
    end

    assign arith = (fn == FnAdd) || (fn == FnSubr) || (fn == FnSubs);
    assign rp    = (fn == FnSubr) ? ~r : r;
    assign sp    = (fn == FnSubs) ? ~s : s;
    assign sum   = {1'b0, rp} + {1'b0, sp} + {{W{1'b0}}, cin};
    // Carry into the MSB recovered from the MSB sum bit.
    assign c_msb = sum[W-1] ^ rp[W-1] ^ sp[W-1];

    always_comb begin
        gen = 1'b0;
        for (int k = 0; k < W; k++) begin
            gen = (rp[k] & sp[k]) | ((rp[k] | sp[k]) & gen);
        end
    end

    always_comb begin
        f = sum[W-1:0];
        case (fn)
            FnOr:    f = r | s;
            FnAnd:   f = r & s;
            FnNotrs: f = ~r & s;
            FnExor:  f = r ^ s;
            FnExnor: f = ~(r ^ s);
            default: f = sum[W-1:0];
        endcase
    end

    assign cn4    = arith & sum[W];
    assign ovr    = arith & (c_msb ^ sum[W]);
    assign g_n    = ~(arith & gen);
    assign p_n    = ~(arith & (&(rp | sp)));
    assign f3     = f[W-1];
    assign f_zero = (f == '0);

    always_comb begin
        y         = f;
        ram_we    = 1'b1;
        ram_wdata = f;
        q_we      = 1'b0;
        q_d       = q_q;
        case (dst)
            DstQreg: begin ram_we = 1'b0; q_we = 1'b1; q_d = f; end
            DstNop:  ram_we = 1'b0;
            DstRama: y = ram_a;
            DstRamf: ram_wdata = f;
            DstRamqd: begin
                ram_wdata = {ram3_in, f[W-1:1]};
                q_we      = 1'b1;
                q_d       = {q3_in, q_q[W-1:1]};
            end
            DstRamd: ram_wdata = {ram3_in, f[W-1:1]};
            DstRamqu: begin
                ram_wdata = {f[W-2:0], ram0_in};
                q_we      = 1'b1;
                q_d       = {q_q[W-2:0], q0_in};
            end
            DstRamu: ram_wdata = {f[W-2:0], ram0_in};
        endcase
    end

    // Shift-out drivers stay disabled while reset is held.
    assign ram0_oe  = rst_n & ((dst == DstRamqd) || (dst == DstRamd));
    assign q0_oe    = ram0_oe;
    assign ram3_oe  = rst_n & ((dst == DstRamqu) || (dst == DstRamu));
    assign q3_oe    = ram3_oe;
    assign ram0_out = f[0];
    assign ram3_out = f[W-1];
    assign q0_out   = q_q[0];
    assign q3_out   = q_q[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (ce && q_we) begin
            q_q <= q_d;
        end
    end

endmodule

// File: tb/tb_am2901.sv
// Scoreboard bench for am2901: an arithmetic reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_am2901;

    localparam int W    = 4;
    localparam int Mask = 15;

    typedef struct packed {
        logic [3:0] y;
        logic [5:0] flags;   // f3, f_zero, cn4, ovr, g_n, p_n
        logic [7:0] sh;      // ram0 out/oe, ram3 out/oe, q0 out/oe, q3 out/oe
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic [8:0]   i = '0;
    logic [3:0]   a = '0, b = '0;
    logic [W-1:0] d = '0;
    logic         cin = 1'b0, ram0_in = 1'b0, ram3_in = 1'b0, q0_in = 1'b0, q3_in = 1'b0;
    logic         ram0_out, ram0_oe, ram3_out, ram3_oe, q0_out, q0_oe, q3_out, q3_oe;
    logic [W-1:0] y;
    logic         f3, f_zero, cn4, ovr, g_n, p_n;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    exp_t       exp_q[$];
    logic [3:0] m_ram [16];
    logic [3:0] m_q;

    always #5 clk = ~clk;

    am2901 #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .i        (i),
        .a        (a),
        .b        (b),
        .d        (d),
        .cin      (cin),
        .ram0_in  (ram0_in),
        .ram3_in  (ram3_in),
        .q0_in    (q0_in),
        .q3_in    (q3_in),
        .ram0_out (ram0_out),
        .ram0_oe  (ram0_oe),
        .ram3_out (ram3_out),
        .ram3_oe  (ram3_oe),
        .q0_out   (q0_out),
        .q0_oe    (q0_oe),
        .q3_out   (q3_out),
        .q3_oe    (q3_oe),
        .y        (y),
        .f3       (f3),
        .f_zero   (f_zero),
        .cn4      (cn4),
        .ovr      (ovr),
        .g_n      (g_n),
        .p_n      (p_n)
    );

    // Reference model: plain integer arithmetic on the current inputs and model state.
    task automatic model(output exp_t e, output bit ram_wr, output int ram_nv,
                         output bit q_wr, output int q_nv);
        int r, s, rp, sp, tot, f, sr, ss, st, fn, dst;
        bit c4, ov, gn, pn, oe_dn, oe_up;
        r = 0; s = 0; c4 = 0; ov = 0; gn = 1; pn = 1;
        case (i[2:0])
            3'd0: begin r = m_ram[a]; s = m_q;      end
            3'd1: begin r = m_ram[a]; s = m_ram[b]; end
            3'd2: s = m_q;
            3'd3: s = m_ram[b];
            3'd4: s = m_ram[a];
            3'd5: begin r = d; s = m_ram[a]; end
            3'd6: begin r = d; s = m_q;      end
            default: r = d;
        endcase
        fn  = i[5:3];
        dst = i[8:6];
        if (fn <= 2) begin
            rp  = (fn == 1) ? Mask - r : r;
            sp  = (fn == 2) ? Mask - s : s;
            tot = rp + sp + cin;
            f   = tot % 16;
            c4  = (tot >= 16);
            sr  = (rp >= 8) ? rp - 16 : rp;
            ss  = (sp >= 8) ? sp - 16 : sp;
            st  = sr + ss + cin;
            ov  = (st > 7) || (st < -8);
            gn  = !(rp + sp >= 16);
            pn  = !((rp | sp) == Mask);
        end else begin
            case (fn)
                3: f = r | s;
                4: f = r & s;
                5: f = (Mask - r) & s;
                6: f = r ^ s;
                default: f = Mask - (r ^ s);
            endcase
        end
        oe_dn = rst_n && (dst == 4 || dst == 5);
        oe_up = rst_n && (dst == 6 || dst == 7);
        e.y     = (dst == 2) ? m_ram[a] : 4'(f);
        e.flags = {f >= 8, f == 0, c4, ov, gn, pn};
        e.sh    = {f[0], oe_dn, f[3], oe_up, m_q[0], oe_dn, m_q[3], oe_up};
        ram_wr = (dst >= 2);
        ram_nv = f;
        if (dst == 4 || dst == 5) ram_nv = (f / 2) + (ram3_in ? 8 : 0);
        if (dst == 6 || dst == 7) ram_nv = ((f * 2) % 16) + (ram0_in ? 1 : 0);
        q_wr = (dst == 0 || dst == 4 || dst == 6);
        q_nv = f;
        if (dst == 4) q_nv = (m_q / 2) + (q3_in ? 8 : 0);
        if (dst == 6) q_nv = ((m_q * 2) % 16) + (q0_in ? 1 : 0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) m_ram[k] = '0;
        m_q = '0;
    endtask

    task automatic drive(input logic ce_v, input logic [8:0] i_v, input logic [3:0] a_v,
                         input logic [3:0] b_v, input logic [3:0] d_v, input logic cin_v,
                         input logic r0, input logic r3, input logic qz, input logic qt,
                         input bit do_reset);
        exp_t e;
        bit   ram_wr, q_wr;
        int   ram_nv, q_nv;
        ce = ce_v; i = i_v; a = a_v; b = b_v; d = d_v; cin = cin_v;
        ram0_in = r0; ram3_in = r3; q0_in = qz; q3_in = qt;
        #0;
        model(e, ram_wr, ram_nv, q_wr, q_nv);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        if (do_reset) begin
            rst_n = 1'b0;
            clear_model();
        end else if (rst_n && ce_v) begin
            if (ram_wr) m_ram[b_v] = 4'(ram_nv);
            if (q_wr) m_q = 4'(q_nv);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the oldest expectation against the DUT at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL y txn %0d: got %h want %h (i=%o a=%h b=%h d=%h)",
                             txn, y, e.y, i, a, b, d);
                end
                checks++;
                if ({f3, f_zero, cn4, ovr, g_n, p_n} !== e.flags) begin
                    errors++;
                    $display("FAIL flags txn %0d: got %b want %b (i=%o cin=%b)",
                             txn, {f3, f_zero, cn4, ovr, g_n, p_n}, e.flags, i, cin);
                end
                checks++;
                if ({ram0_out, ram0_oe, ram3_out, ram3_oe, q0_out, q0_oe, q3_out, q3_oe}
                    !== e.sh) begin
                    errors++;
                    $display("FAIL shift txn %0d: got %b want %b (i=%o)", txn,
                             {ram0_out, ram0_oe, ram3_out, ram3_oe, q0_out, q0_oe, q3_out,
                              q3_oe}, e.sh, i);
                end
            end
        end
    end

    initial begin
        int unsigned v;
        clear_model();
        #2;
        // In reset: ZA/ADD/NOP reads zeros, all drivers off.
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd4, 3'd0, 3'd7}, 4'd1, 4'd2, 4'd9, 0, 1, 1, 0, 0, 0);
        rst_n = 1'b1;
        // Load RAM[3]=7 then D(9)+RAM[3] into RAM[3]; read it back.
        drive(1, {3'd3, 3'd0, 3'd7}, 4'd0, 4'd3, 4'd7, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd3, 3'd0, 3'd5}, 4'd3, 4'd3, 4'd9, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd3, 4'd3, 4'd0, 0, 0, 0, 0, 0, 0);
        // R=S=5 SUBS with cin 1 and 0.
        drive(1, {3'd3, 3'd0, 3'd7}, 4'd0, 4'd4, 4'd5, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd1, 3'd2, 3'd5}, 4'd4, 4'd4, 4'd5, 1, 0, 0, 0, 0, 0);
        drive(1, {3'd1, 3'd2, 3'd5}, 4'd4, 4'd4, 4'd5, 0, 0, 0, 0, 0, 0);
        // Q=1001, F=0110 RAMQD into RAM[5]; read back RAM[5] and Q.
        drive(1, {3'd0, 3'd0, 3'd7}, 4'd0, 4'd0, 4'd9, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd4, 3'd0, 3'd7}, 4'd0, 4'd5, 4'd6, 0, 0, 1, 0, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd5, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd2}, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        // Q=0011, F=1010 RAMQU, first with ce=0 then ce=1.
        drive(1, {3'd0, 3'd0, 3'd7}, 4'd0, 4'd0, 4'd3, 0, 0, 0, 0, 0, 0);
        drive(0, {3'd6, 3'd0, 3'd7}, 4'd0, 4'd6, 4'd10, 0, 1, 0, 1, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd6, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd6, 3'd0, 3'd7}, 4'd0, 4'd6, 4'd10, 0, 1, 0, 1, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd6, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        drive(1, {3'd1, 3'd0, 3'd2}, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            v = $urandom;
            drive((v[3:0] != 0), 9'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  v[4], v[5], v[6], v[7], v[8], 0);
        end
        // Reset lands after a write is set up; it must be discarded.
        drive(1, {3'd3, 3'd0, 3'd7}, 4'd0, 4'd8, 4'd12, 0, 0, 0, 0, 0, 1);
        drive(1, {3'd1, 3'd0, 3'd4}, 4'd8, 4'd8, 4'd0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1, {3'd1, 3'd0, 3'd1}, 4'(k), 4'(15 - k), 4'd0, 0, 0, 0, 0, 0, 0);
        end
        drive(1, {3'd1, 3'd0, 3'd2}, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
